// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller: event kinds, queued event record
// and the per-button hold FSM states.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_kind_t;

  // Wide enough for any practical button count; the top narrows it to clog2(N_BTN).
  localparam int unsigned EVT_BTN_W = 8;

  typedef struct packed {
    logic [EVT_BTN_W-1:0] btn;
    evt_kind_t            kind;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } hold_state_t;

endpackage

// File: rtl/btn_hold_fsm.sv
// One button: press/long/repeat/release detection with a hold counter and a
// one-entry pending register that the arbiter drains via grant.
module btn_hold_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn,
  input  logic      grant,
  output logic      pend_valid,
  output evt_kind_t pend_kind,
  output logic      held,
  output logic      drop
);

  localparam int unsigned CNT_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  hold_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             emit;
  evt_kind_t        emit_kind;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Release is checked first so it wins over a threshold hit in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_kind  = EVT_PRESS;
    unique case (state)
      ST_IDLE: begin
        if (btn) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
          emit       = 1'b1;
          emit_kind  = EVT_PRESS;
        end
      end
      ST_PRESSED: begin
        if (!btn) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          emit       = 1'b1;
          emit_kind  = EVT_RELEASE;
        end else if (cnt == CNT_W'(LONG_CYC - 1)) begin
          state_next = ST_LONG_HELD;
          cnt_next   = '0;
          emit       = 1'b1;
          emit_kind  = EVT_LONG;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (!btn) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          emit       = 1'b1;
          emit_kind  = EVT_RELEASE;
        end else if (cnt == CNT_W'(REPEAT_CYC - 1)) begin
          cnt_next  = '0;
          emit      = 1'b1;
          emit_kind = EVT_REPEAT;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A grant in the same cycle frees the slot, so a new event may refill it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_kind  <= EVT_PRESS;
    end else if (emit && (!pend_valid || grant)) begin
      pend_valid <= 1'b1;
      pend_kind  <= emit_kind;
    end else if (grant) begin
      pend_valid <= 1'b0;
    end
  end

  assign drop = emit && pend_valid && !grant;
  assign held = (state != ST_IDLE);

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: per-button hold FSMs, round-robin arbiter and a
// first-word fall-through event queue with valid/ready output.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_state,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [1:0]               evt_kind,
  output logic [N_BTN-1:0]         held,
  output logic                     overflow
);

  localparam int unsigned BTN_W = $clog2(N_BTN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [N_BTN-1:0] pend_valid;
  evt_kind_t        pend_kind [N_BTN];
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] drop;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_hold_fsm #(
      .LONG_CYC  (LONG_CYC),
      .REPEAT_CYC(REPEAT_CYC)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn_state[i]),
      .grant     (grant[i]),
      .pend_valid(pend_valid[i]),
      .pend_kind (pend_kind[i]),
      .held      (held[i]),
      .drop      (drop[i])
    );
  end

  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [BTN_W-1:0] rr_ptr;
  logic [BTN_W-1:0] grant_idx;
  logic             grant_any, push, pop, full;
  evt_t             entry, head;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;

  // Search starts at rr_ptr, the index after the most recent grant.
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      j = (32'(rr_ptr) + k) % N_BTN;
      if (!grant_any && pend_valid[BTN_W'(j)]) begin
        grant_any = 1'b1;
        grant_idx = BTN_W'(j);
      end
    end
  end

  assign push       = grant_any && (!full || pop);
  assign grant      = push ? (N_BTN'(1) << grant_idx) : '0;
  assign entry.btn  = EVT_BTN_W'(grant_idx);
  assign entry.kind = pend_kind[grant_idx];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= (grant_idx == BTN_W'(N_BTN - 1)) ? '0 : grant_idx + BTN_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (|drop) overflow <= 1'b1;
    end
  end

  assign head     = mem[rd_ptr];
  assign evt_btn  = evt_valid ? head.btn[BTN_W-1:0] : '0;
  assign evt_kind = evt_valid ? head.kind : EVT_PRESS;

  logic unused_head_btn;
  assign unused_head_btn = ^head.btn;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed vector table, hand sequences and
// randomized stimulus against an event-level reference model.
module tb_button_event_ctrl;

  localparam int NB = 4, LONG = 8, REP = 4, DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic [1:0] evt_kind;
  logic [3:0] held;
  logic       overflow;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN     (NB),
    .LONG_CYC  (LONG),
    .REPEAT_CYC(REP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_kind (evt_kind),
    .held     (held),
    .overflow (overflow)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Reference model: events derived from how long each button has been held,
  // pending slots, a rotating grant start and a queue of delivered events.
  typedef struct { int btn; int kind; } mev_t;
  mev_t mq[$];
  mev_t acc[$];
  bit   m_on  [NB];
  int   m_age [NB];
  bit   m_pend[NB];
  int   m_pk  [NB];
  int   m_rr;
  bit   m_ovf;

  task automatic model_step();
    bit pop;
    int g;
    int ev;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < NB; i++) begin
        m_on[i] = 0; m_age[i] = 0; m_pend[i] = 0; m_pk[i] = 0;
      end
      m_rr  = 0;
      m_ovf = 0;
      return;
    end
    pop = (mq.size() > 0) && evt_ready;
    g   = -1;
    if (mq.size() < DEPTH || pop)
      for (int k = 0; k < NB; k++) begin
        int j;
        j = (m_rr + k) % NB;
        if (g < 0 && m_pend[j]) g = j;
      end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{g, m_pk[g]});
      m_rr = (g + 1) % NB;
    end
    for (int i = 0; i < NB; i++) begin
      ev = -1;
      if (!m_on[i] && btn_state[i]) begin
        ev = 0; m_on[i] = 1; m_age[i] = 0;
      end else if (m_on[i] && !btn_state[i]) begin
        ev = 3; m_on[i] = 0;
      end else if (m_on[i]) begin
        m_age[i]++;
        if (m_age[i] == LONG) ev = 1;
        else if (m_age[i] > LONG && (m_age[i] - LONG) % REP == 0) ev = 2;
      end
      if (ev >= 0) begin
        if (!m_pend[i] || g == i) begin m_pend[i] = 1; m_pk[i] = ev; end
        else m_ovf = 1;
      end else if (g == i) begin
        m_pend[i] = 0;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] exp_h;
    if (evt_valid === 1'b1 && evt_ready && !rst) acc.push_back('{int'(evt_btn), int'(evt_kind)});
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) exp_h[i] = m_on[i];
    chk("evt_valid", evt_valid, mq.size() > 0);
    chk("evt_btn", evt_btn, (mq.size() > 0) ? mq[0].btn : 0);
    chk("evt_kind", evt_kind, (mq.size() > 0) ? mq[0].kind : 0);
    chk("held", held, exp_h);
    chk("overflow", overflow, m_ovf);
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       v;
    logic [1:0] b;
    logic [1:0] k;
    logic [3:0] h;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] btn, input logic rdy, input logic v,
                              input logic [1:0] b, input logic [1:0] k, input logic [3:0] h);
    tbl.push_back('{btn, rdy, v, b, k, h});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int n_long, n_rep;
    int exp_k[6];
    // short press of btn 2, then btn 3 released exactly at the LONG threshold
    add(4'b0100, 1, 0, 0, 0, 4'b0100);
    add(4'b0100, 1, 1, 2, 0, 4'b0100);
    add(4'b0100, 1, 0, 0, 0, 4'b0100);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 1, 2, 3, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b1000, 1, 0, 0, 0, 4'b1000);
    add(4'b1000, 1, 1, 3, 0, 4'b1000);
    for (int i = 0; i < 6; i++) add(4'b1000, 1, 0, 0, 0, 4'b1000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 1, 3, 3, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);

    rst = 1'b1; btn_state = '0; evt_ready = 1'b1;
    tick(); tick();
    chk("reset_outputs", {evt_valid, evt_btn, evt_kind, held, overflow}, '0);
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      btn_state = tbl[n].btn;
      evt_ready = tbl[n].rdy;
      tick();
      chk($sformatf("vec%0d", n), {evt_valid, evt_btn, evt_kind, held},
          {tbl[n].v, tbl[n].b, tbl[n].k, tbl[n].h});
    end
    chk("vec_no_overflow", overflow, 1'b0);

    // long hold on btn 0: PRESS, LONG, three REPEATs, RELEASE
    acc.delete();
    btn_state = 4'b0001;
    for (int i = 0; i < 21; i++) tick();
    btn_state = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    exp_k = '{0, 1, 2, 2, 2, 3};
    chk("hold_event_count", acc.size(), 6);
    n_long = 0; n_rep = 0;
    foreach (acc[i]) begin
      if (acc[i].kind == 1) n_long++;
      if (acc[i].kind == 2) n_rep++;
    end
    chk("hold_long_count", n_long, 1);
    chk("hold_repeat_count", n_rep, 3);
    if (acc.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("hold_kind%0d", i), acc[i].kind, exp_k[i]);

    // simultaneous bursts: presses then releases, both served 0,1,2,3
    acc.delete();
    btn_state = 4'b1111;
    for (int i = 0; i < 6; i++) tick();
    btn_state = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    chk("burst_count", acc.size(), 8);
    if (acc.size() == 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("burst%0d", i), {acc[i].btn, acc[i].kind}, {i % 4, (i < 4) ? 0 : 3});

    // stalled consumer: 6 events on btn 1, 4 queued, 1 pending, 1 dropped
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_state = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    btn_state = 4'b0000;
    tick(); tick();
    chk("stall_overflow", overflow, 1'b1);
    chk("stall_head", {evt_valid, evt_btn, evt_kind}, {1'b1, 2'd1, 2'd0});
    acc.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_drain_count", acc.size(), 5);

    // reset with 2 queued events and btn 0 held
    evt_ready = 1'b0;
    btn_state = 4'b0011;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_reset_valid", evt_valid, 1'b1);
    rst = 1'b1; btn_state = 4'b0001;
    tick();
    chk("mid_reset_outputs", {evt_valid, evt_btn, evt_kind, held, overflow}, '0);
    rst = 1'b0; evt_ready = 1'b1;
    tick();
    chk("post_reset_first", evt_valid, 1'b0);
    tick();
    chk("post_reset_press", {evt_valid, evt_btn, evt_kind}, {1'b1, 2'd0, 2'd0});
    btn_state = 4'b0000;
    for (int i = 0; i < 4; i++) tick();

    // randomized phase with stall windows and occasional reset
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 11) == 0) btn_state[b] = ~btn_state[b];
      evt_ready = ($urandom_range(0, 99) < ((i % 600 < 120) ? 10 : 80));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
